// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
// Optional statistics counters are enabled by defining ICACHE_STATS_EN.
package icache_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t MEM_READ = 2'd1;
    localparam state_t UPDATE   = 2'd2;

    function automatic int off_w(int words);
        return $clog2(words);
    endfunction

    function automatic int blk_w(int addr_bits, int words);
        return addr_bits - $clog2(words) - 2;
    endfunction

    function automatic int tag_w(int addr_bits, int words, int lines);
        return blk_w(addr_bits, words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache.
// One write port, one combinational read port, async clear of valid bits.
module icache_line_array #(
    parameter int LINES  = 8,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 128,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [TAG_W-1:0]  wtag,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic              rvalid,
    output logic [TAG_W-1:0]  rtag,
    output logic [DATA_W-1:0] rdata
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[widx] <= 1'b1;
        end
    end

    // Tag and data need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[widx]  <= wtag;
            data_q[widx] <= wdata;
        end
    end

    assign rvalid = valid_q[ridx];
    assign rtag   = tag_q[ridx];
    assign rdata  = data_q[ridx];

endmodule

// File: rtl/instr_cache_fetch.sv
// Read-only direct-mapped instruction cache with block refill FSM.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module instr_cache_fetch
    import icache_pkg::*;
#(
    parameter int NUM_LINES       = 8,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int ADDR_BITS       = 10
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] PC,
    output logic [31:0] INSTRUCTION,
    output logic        BUSYWAIT,
    output logic        mem_read,
    output logic [blk_w(ADDR_BITS, WORDS_PER_BLOCK)-1:0] mem_address,
    input  logic [WORDS_PER_BLOCK*32-1:0] mem_readdata,
    input  logic        mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int OFF_W  = off_w(WORDS_PER_BLOCK);
    localparam int BYTE_W = OFF_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int BA_W   = blk_w(ADDR_BITS, WORDS_PER_BLOCK);
    localparam int TAG_W  = tag_w(ADDR_BITS, WORDS_PER_BLOCK, NUM_LINES);
    localparam int DATA_W = WORDS_PER_BLOCK * 32;

    state_t            state_q;
    logic [BA_W-1:0]   blk_q;
    logic [DATA_W-1:0] fill_q;

    logic [BA_W-1:0]   pc_blk;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [OFF_W-1:0]  pc_off;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              idle;
    logic              hit;
    logic              unused_pc;

    assign pc_blk = PC[ADDR_BITS-1:BYTE_W];
    assign pc_idx = pc_blk[IDX_W-1:0];
    assign pc_tag = pc_blk[BA_W-1:IDX_W];
    assign pc_off = PC[BYTE_W-1:2];
    assign unused_pc = ^{PC[31:ADDR_BITS], PC[1:0]};

    icache_line_array #(
        .LINES  (NUM_LINES),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_lines (
        .clk    (CLK),
        .rst    (RESET),
        .we     (state_q == UPDATE),
        .widx   (blk_q[IDX_W-1:0]),
        .wtag   (blk_q[BA_W-1:IDX_W]),
        .wdata  (fill_q),
        .ridx   (pc_idx),
        .rvalid (rd_valid),
        .rtag   (rd_tag),
        .rdata  (rd_data)
    );

    assign idle = (state_q == IDLE);
    assign hit  = rd_valid && (rd_tag == pc_tag);

    assign INSTRUCTION = RESET ? 32'h0 : rd_data[{pc_off, 5'b0} +: 32];
    assign BUSYWAIT    = !RESET && (!idle || !hit);
    assign mem_read    = (state_q == MEM_READ);
    assign mem_address = blk_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            blk_q   <= '0;
            fill_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!hit) begin
                        blk_q   <= pc_blk;
                        state_q <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        fill_q  <= mem_readdata;
                        state_q <= UPDATE;
                    end
                end
                UPDATE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (idle) begin
            if (hit && hit_count != 16'hFFFF) begin
                hit_count <= hit_count + 16'd1;
            end
            if (!hit && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_cache_fetch.sv
// Self-checking bench for instr_cache_fetch: directed table, reset
// mid-fill sequence and random accesses against a line-level model.
module tb_instr_cache_fetch;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    int checks = 0;
    int errors = 0;
    int busy_cfg = 0;
    int left = 0;

    bit mvalid [8];
    int mtag   [8];
    int mhits  = 0;
    int mmiss  = 0;

    instr_cache_fetch dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(int a);
        return 32'hAB00_0000 | (a & 32'h3FC);
    endfunction

    always_comb begin
        mem_readdata = '0;
        for (int w = 0; w < 4; w++) begin
            mem_readdata[w*32 +: 32] = mem_word(int'(mem_address) * 16 + w * 4);
        end
    end

    // Memory: busy for busy_cfg cycles of an active read, then data valid.
    initial mem_busywait = 1'b0;
    always begin
        @(posedge CLK);
        #2;
        if (mem_read) begin
            if (left > 0) begin
                mem_busywait = 1'b1;
                left = left - 1;
            end else begin
                mem_busywait = 1'b0;
            end
        end else begin
            mem_busywait = 1'b0;
            left = busy_cfg;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = 0;
        end
        mhits = 0;
        mmiss = 0;
    endtask

    function automatic bit model_hit(int pc);
        int idx = (pc >> 4) & 7;
        int tg  = (pc >> 7) & 7;
        return mvalid[idx] && mtag[idx] == tg;
    endfunction

    task automatic model_access(input int pc);
        int idx = (pc >> 4) & 7;
        if (!model_hit(pc)) mmiss++;
        mvalid[idx] = 1'b1;
        mtag[idx]   = (pc >> 7) & 7;
        mhits++;
    endtask

    // Entered and left at posedge+1; samples at negedge.
    task automatic access(input logic [31:0] pc, input int b,
                          output bit missed, output int stall, output int mrc,
                          output logic [5:0] maddr, output logic [31:0] instr);
        bit done = 1'b0;
        PC = pc;
        busy_cfg = b;
        missed = 1'b0;
        stall = 0;
        mrc = 0;
        maddr = '0;
        instr = '0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge CLK);
            if (!BUSYWAIT) begin
                instr = INSTRUCTION;
                done = 1'b1;
            end else begin
                if (c == 0) missed = 1'b1;
                else stall++;
                if (mem_read) begin
                    mrc++;
                    maddr = mem_address;
                end
            end
            @(posedge CLK);
            #1;
        end
        check("access_timeout", {31'b0, done}, 32'd1);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        check("rst_instr", INSTRUCTION, 32'h0);
        check("rst_busy", {31'b0, BUSYWAIT}, 32'd0);
        check("rst_mem_read", {31'b0, mem_read}, 32'd0);
        check("rst_mem_addr", {26'b0, mem_address}, 32'd0);
        repeat (10) @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_clear();
    endtask

    typedef struct {
        logic [31:0] pc;
        int          busy;
        bit          hit;
        logic [31:0] instr;
        int          mrc;
        logic [5:0]  maddr;
    } vec_t;

    vec_t vecs [10];

    bit          missed;
    int          stall;
    int          mrc;
    logic [5:0]  maddr;
    logic [31:0] instr;

    initial begin
        RESET = 1'b1;
        PC    = 32'h0;
        model_clear();

        vecs[0] = '{32'h000, 5, 1'b0, 32'hAB00_0000, 6, 6'h00};
        vecs[1] = '{32'h004, 0, 1'b1, 32'hAB00_0004, 0, 6'h00};
        vecs[2] = '{32'h008, 0, 1'b1, 32'hAB00_0008, 0, 6'h00};
        vecs[3] = '{32'h00C, 0, 1'b1, 32'hAB00_000C, 0, 6'h00};
        vecs[4] = '{32'h080, 2, 1'b0, 32'hAB00_0080, 3, 6'h08};
        vecs[5] = '{32'h000, 0, 1'b0, 32'hAB00_0000, 1, 6'h00};
        vecs[6] = '{32'h400, 0, 1'b1, 32'hAB00_0000, 0, 6'h00};
        vecs[7] = '{32'h40C, 0, 1'b1, 32'hAB00_000C, 0, 6'h00};
        vecs[8] = '{32'h3FC, 1, 1'b0, 32'hAB00_03FC, 2, 6'h3F};
        vecs[9] = '{32'h7FC, 0, 1'b1, 32'hAB00_03FC, 0, 6'h00};

        @(posedge CLK);
        #1;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            access(vecs[i].pc, vecs[i].busy, missed, stall, mrc, maddr, instr);
            model_access(vecs[i].pc);
            check($sformatf("t%0d_miss", i), {31'b0, missed}, {31'b0, !vecs[i].hit});
            check($sformatf("t%0d_instr", i), instr, vecs[i].instr);
            check($sformatf("t%0d_stall", i), stall, vecs[i].hit ? 0 : vecs[i].busy + 2);
            check($sformatf("t%0d_mem_read_cycles", i), mrc, vecs[i].mrc);
            if (!vecs[i].hit) begin
                check($sformatf("t%0d_mem_addr", i), {26'b0, maddr}, {26'b0, vecs[i].maddr});
            end
        end

`ifdef ICACHE_STATS_EN
        check("stat_hits_table", {16'b0, hit_count}, mhits);
        check("stat_miss_table", {16'b0, miss_count}, mmiss);
`endif

        // Reset in the third MEM_READ cycle of a cold miss.
        do_reset();
        PC = 32'h000;
        busy_cfg = 10;
        @(negedge CLK);
        check("mr_detect_busy", {31'b0, BUSYWAIT}, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            check($sformatf("mr_cycle%0d_read", k), {31'b0, mem_read}, 32'd1);
        end
        RESET = 1'b1;
        #1;
        check("mr_abort_read", {31'b0, mem_read}, 32'd0);
        check("mr_abort_busy", {31'b0, BUSYWAIT}, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_clear();
        access(32'h000, 2, missed, stall, mrc, maddr, instr);
        model_access(32'h000);
        check("mr_refetch_miss", {31'b0, missed}, 32'd1);
        check("mr_refetch_instr", instr, 32'hAB00_0000);
        check("mr_refetch_stall", stall, 4);

        for (int n = 0; n < 150; n++) begin
            int pc;
            int b;
            bit eh;
            pc = ($urandom_range(0, 1) << 10) | ($urandom_range(0, 3) << 7)
               | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
            b  = $urandom_range(0, 3);
            eh = model_hit(pc);
            access(pc, b, missed, stall, mrc, maddr, instr);
            check($sformatf("r%0d_miss", n), {31'b0, missed}, {31'b0, !eh});
            check($sformatf("r%0d_instr", n), instr, mem_word(pc));
            check($sformatf("r%0d_stall", n), stall, eh ? 0 : b + 2);
            if (!eh) begin
                check($sformatf("r%0d_mem_addr", n), {26'b0, maddr}, (pc >> 4) & 63);
            end
            model_access(pc);
        end

`ifdef ICACHE_STATS_EN
        check("stat_hits_final", {16'b0, hit_count}, mhits);
        check("stat_miss_final", {16'b0, miss_count}, mmiss);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
